edge_capture_bank: RTL and testbench
====================================

# edge_capture_bank

Multi-channel, edge-selectable capture bank with asynchronous reset. Each channel samples a DATA_W-bit field of a packed input bus on the active clock edge into a holding register. A round-robin arbiter drains pending channels into a shared tagged FIFO with a valid/ready output port. It replaces single hard-wired negedge capture registers in the fuzz-harness datapath and adds per-channel overrun flags.

## Interface
- DATA_W, 7: width of one captured channel field.
- NUM_CH, 4: number of capture channels, 1..16.
- DEPTH, 4: FIFO entries, power of two, ≥2.
- NEG_EDGE, 1: 1 = every flop triggers on negedge clkin_data; 0 = posedge.
- CH_W, derived: max(1, $clog2(NUM_CH)).
- clkin_data  in  1  clock; active edge selected by NEG_EDGE.
- reset  in  1  asynchronous, active-high; takes effect on its posedge regardless of clock.
- in_data  in  NUM_CH*DATA_W  channel c field = in_data[c*DATA_W +: DATA_W].
- cap_en  in  NUM_CH  per-channel capture enable, sampled on the active edge.
- out_ready  in  1  consumer accepts the head entry.
- drop_clr  in  NUM_CH  clears the matching drop bits.
- out_valid  out  1  FIFO non-empty.
- out_data  out  DATA_W  head entry data.
- out_ch  out  CH_W  head entry channel index.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- drop  out  NUM_CH  sticky per-channel overrun flags.

## Operation
- Capture: on an active edge with cap_en[c]=1, set cap_q[c] to the channel field and set pend[c].
- Overrun: capture while pend[c]=1 and channel c is not granted that edge: overwrite cap_q[c], set drop[c].
- Arbiter: on each active edge where the FIFO is not full and any pend bit is set, grant the first pending channel at or after rr_ptr (wrapping).
  - Push {g, cap_q[g]}, clear pend[g], set rr_ptr to g+1 mod NUM_CH.
- Grant and capture on the same channel, same edge: the old value is pushed, the new value is held, pend stays 1, drop is not set.
- Full: no grant, even if a pop occurs on the same edge. The push decision uses pre-edge full.
- Pop: on an active edge with out_valid & out_ready, advance the head. Pop when empty is ignored.
- Simultaneous push and pop when not full: level is unchanged.
- drop_clr[c] and an overrun on the same edge: set wins.
- Inactive clock edge: no state changes.

## Timing
- Reset values (all immediate on reset rising): out_valid 0, out_data 0, out_ch 0, level 0, drop 0, cap_q 0, pend 0, rr_ptr 0, FIFO pointers 0.
- Reset asserted mid-operation discards all pending and buffered entries. No clock edge is needed.
- Latency: capture at active edge k → FIFO push at edge k+1 (if not blocked) → out_valid=1 after edge k+1.
- FIFO is show-ahead: out_data and out_ch are valid whenever out_valid=1, with no extra read cycle.
- Sustained throughput: one push and one pop per active edge.
- Level range is 0..DEPTH. Pointers wrap modulo DEPTH; full/empty use an extra wrap bit.

## Structure
- Package edge_capture_pkg holds:
  - default parameter constants (DATA_W_DEF=7, NUM_CH_DEF=4, DEPTH_DEF=4);
  - a round-robin find-first function: pending vector plus start index → grant index and found flag.
- Sub-module edge_capture_fifo (parameters WIDTH, DEPTH, NEG_EDGE): show-ahead FIFO with push, pop, full, empty and level. It uses the same clock/reset edge convention as the top block.
- The top level contains the capture registers, pend/drop bits and the arbiter.

## Test plan
All scenarios use DATA_W=7, NUM_CH=4, DEPTH=4, NEG_EDGE=1 unless stated.
- Reset held: reset=1, cap_en=4'hF, in_data toggling for 10 clocks → out_valid=0, level=0, drop=0 throughout.
- Single capture: ch0 field=7'h1F, cap_en=4'b0001 for one negedge → after the next negedge, out_valid=1, out_ch=0, out_data=7'h1F. No change on posedges.
- Four channels on one edge: fields 7'h11/22/33/44, out_ready=0 → level 1,2,3,4 on successive negedges, pop order ch0..ch3 with matching data.
- Overrun: FIFO full, ch2 captures 7'h05 then 7'h06 → drop=4'b0100. After one pop, 7'h06 is pushed. drop_clr=4'b0100 clears the flag.
- Async reset mid-operation: level=3, reset pulsed between edges → out_valid, level and pend are 0 immediately, and the next capture behaves as after power-up.
- NEG_EDGE=0 instance, ch1 field=7'h2A: capture occurs only on a posedge; an output delay of 2 posedges is checked.

Source files
------------

// File: rtl/edge_capture_pkg.sv
// Shared constants and the round-robin helper for the edge capture bank.
package edge_capture_pkg;

  localparam int DATA_W_DEF = 7;
  localparam int NUM_CH_DEF = 4;
  localparam int DEPTH_DEF  = 4;
  localparam int MAX_CH     = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_grant_t;

  // First set bit of pend at or after start, wrapping within num_ch channels.
  function automatic rr_grant_t rr_find(input logic [MAX_CH-1:0] pend,
                                        input logic [3:0]        start,
                                        input int unsigned       num_ch);
    rr_grant_t   res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      j = (32'(start) + k) % num_ch;
      if (!res.found && (k < num_ch) && pend[j[3:0]]) begin
        res.found = 1'b1;
        res.idx   = j[3:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/edge_capture_bank_if.sv
// Tagged valid/ready output stream of the capture bank.
interface edge_capture_bank_if
  import edge_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CH_W   = 2
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_ch;

  modport master (output out_valid, out_data, out_ch, input out_ready);
  modport slave  (input out_valid, out_data, out_ch, output out_ready);
endinterface

// File: rtl/edge_capture_fifo.sv
// Show-ahead FIFO; pointers carry an extra wrap bit to tell full from empty.
module edge_capture_fifo
  import edge_capture_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = DEPTH_DEF,
  parameter bit NEG_EDGE = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clkin_data,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic             clk_act;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_eff;
  logic             pop_eff;

  assign clk_act = NEG_EDGE ? ~clkin_data : clkin_data;

  // Status flags and guarded push/pop; head is forced to zero while empty.
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    level    = wr_ptr - rd_ptr;
    push_eff = push & ~full;
    pop_eff  = pop & ~empty;
    pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk_act or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the head is gated by empty.
  always_ff @(posedge clk_act) begin
    if (push_eff) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/edge_capture_bank.sv
// Per-channel capture registers with pending/overrun tracking and a
// round-robin drain into a shared tagged FIFO.
module edge_capture_bank
  import edge_capture_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter bit NEG_EDGE = 1'b1,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic                     clkin_data,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        cap_en,
  input  logic [NUM_CH-1:0]        drop_clr,
  edge_capture_bank_if.master      out_if,
  output logic [LVL_W-1:0]         level,
  output logic [NUM_CH-1:0]        drop
);

  logic                   clk_act;
  logic [DATA_W-1:0]      cap_q [NUM_CH];
  logic [NUM_CH-1:0]      pend;
  logic [NUM_CH-1:0]      overrun;
  logic [CH_W-1:0]        rr_ptr;
  rr_grant_t              rr;
  logic                   grant;
  logic [CH_W-1:0]        gnt_ch;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic [CH_W+DATA_W-1:0] push_word;
  logic [CH_W+DATA_W-1:0] head_word;

  assign clk_act = NEG_EDGE ? ~clkin_data : clkin_data;

  // Arbitration uses the pre-edge full flag, so a same-edge pop never frees a slot for this edge.
  always_comb begin
    rr        = rr_find(16'(pend), 4'(rr_ptr), NUM_CH);
    gnt_ch    = CH_W'(rr.idx);
    grant     = rr.found & ~fifo_full;
    push_word = {gnt_ch, cap_q[gnt_ch]};
    pop       = out_if.out_valid & out_if.out_ready;
  end

  // A capture onto a still-pending channel loses the old value unless that value is drained this edge.
  always_comb begin
    overrun = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      overrun[c] = cap_en[c] & pend[c] & ~(grant && (gnt_ch == CH_W'(c)));
    end
  end

  // Capture, pending, drop and round-robin pointer state; a new capture re-arms pend after its grant.
  always_ff @(posedge clk_act or posedge reset) begin
    if (reset) begin
      pend   <= '0;
      drop   <= '0;
      rr_ptr <= '0;
      for (int c = 0; c < NUM_CH; c++) cap_q[c] <= '0;
    end else begin
      if (grant) begin
        pend[gnt_ch] <= 1'b0;
        rr_ptr       <= CH_W'((32'(gnt_ch) + 32'd1) % 32'(NUM_CH));
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (cap_en[c]) begin
          cap_q[c] <= in_data[c*DATA_W +: DATA_W];
          pend[c]  <= 1'b1;
        end
      end
      drop <= (drop & ~drop_clr) | overrun;
    end
  end

  edge_capture_fifo #(
    .WIDTH   (CH_W + DATA_W),
    .DEPTH   (DEPTH),
    .NEG_EDGE(NEG_EDGE)
  ) u_fifo (
    .clkin_data(clkin_data),
    .reset     (reset),
    .push      (grant),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign out_if.out_valid = ~fifo_empty;
  assign out_if.out_data  = head_word[DATA_W-1:0];
  assign out_if.out_ch    = head_word[CH_W+DATA_W-1:DATA_W];

endmodule

// File: tb/tb_edge_capture_bank.sv
// Bench for edge_capture_bank: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, randomized traffic, and a posedge instance.
module tb_edge_capture_bank;

  localparam int DW = 7;
  localparam int NC = 4;
  localparam int DP = 4;

  logic        clk   = 1'b1;
  logic        reset = 1'b1;
  logic [27:0] in_data  = '0;
  logic [3:0]  cap_en   = '0;
  logic [3:0]  drop_clr = '0;
  logic [2:0]  level;
  logic [3:0]  drop;

  logic [27:0] p_in_data  = '0;
  logic [3:0]  p_cap_en   = '0;
  logic [3:0]  p_drop_clr = '0;
  logic [2:0]  p_level;
  logic [3:0]  p_drop;

  int checks = 0;
  int errors = 0;

  edge_capture_bank_if #(.DATA_W(DW), .CH_W(2)) out_if ();
  edge_capture_bank_if #(.DATA_W(DW), .CH_W(2)) p_if ();

  edge_capture_bank #(.DATA_W(DW), .NUM_CH(NC), .DEPTH(DP), .NEG_EDGE(1'b1)) dut (
    .clkin_data(clk), .reset(reset), .in_data(in_data), .cap_en(cap_en),
    .drop_clr(drop_clr), .out_if(out_if), .level(level), .drop(drop));

  edge_capture_bank #(.DATA_W(DW), .NUM_CH(NC), .DEPTH(DP), .NEG_EDGE(1'b0)) dut_p (
    .clkin_data(clk), .reset(reset), .in_data(p_in_data), .cap_en(p_cap_en),
    .drop_clr(p_drop_clr), .out_if(p_if), .level(p_level), .drop(p_drop));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: captured values, pending/drop flags, rr pointer and a FIFO queue.
  typedef struct { int ch; int data; } ent_t;
  ent_t     q[$];
  int       m_cap [NC];
  bit       m_pend[NC];
  bit [3:0] m_drop = '0;
  int       m_rr   = 0;

  task automatic m_reset();
    q.delete();
    for (int c = 0; c < NC; c++) begin m_cap[c] = 0; m_pend[c] = 0; end
    m_drop = '0;
    m_rr   = 0;
  endtask

  task automatic m_step();
    int g;
    bit popv;
    g    = -1;
    popv = (q.size() > 0) && out_if.out_ready;
    if (q.size() < DP)
      for (int k = 0; k < NC; k++)
        if (g < 0 && m_pend[(m_rr + k) % NC]) g = (m_rr + k) % NC;
    if (popv) void'(q.pop_front());
    if (g >= 0) begin
      q.push_back('{g, m_cap[g]});
      m_pend[g] = 0;
      m_rr = (g + 1) % NC;
    end
    m_drop &= ~drop_clr;
    for (int c = 0; c < NC; c++) begin
      if (cap_en[c]) begin
        if (m_pend[c]) m_drop[c] = 1'b1;
        m_cap[c]  = int'(in_data[c*DW +: DW]);
        m_pend[c] = 1'b1;
      end
    end
  endtask

  always @(posedge reset) m_reset();

  always @(negedge clk) begin
    if (reset) m_reset();
    else m_step();
  end

  // Compare process: outputs must match the model after every active edge (checked past the inactive edge).
  always @(posedge clk) begin
    #2;
    check("cmp_valid", int'(out_if.out_valid), int'(q.size() != 0));
    check("cmp_level", int'(level), q.size());
    check("cmp_drop", int'(drop), int'(m_drop));
    if (q.size() > 0) begin
      check("cmp_head_ch", int'(out_if.out_ch), q[0].ch);
      check("cmp_head_data", int'(out_if.out_data), q[0].data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_valid", int'(out_if.out_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_pend", int'(dut.pend), 0);
    check("rst_drop", int'(drop), 0);
    #1 reset = 1'b0;
  endtask

  initial begin
    int heads_ch [4];
    int heads_dat[4];
    int rdy_pct;
    out_if.out_ready = 1'b0;
    p_if.out_ready   = 1'b0;

    // Reset held with captures requested and data toggling.
    cap_en = 4'hF;
    for (int i = 0; i < 10; i++) begin
      in_data = 28'($urandom);
      step();
      check("hold_valid", int'(out_if.out_valid), 0);
      check("hold_level", int'(level), 0);
      check("hold_drop", int'(drop), 0);
    end
    reset  = 1'b0;
    cap_en = '0;

    // Single capture on ch0.
    step();
    in_data = 28'h000001F;
    cap_en  = 4'b0001;
    step();
    cap_en = '0;
    check("single_not_yet", int'(out_if.out_valid), 0);
    step();
    check("single_valid", int'(out_if.out_valid), 1);
    check("single_ch", int'(out_if.out_ch), 0);
    check("single_data", int'(out_if.out_data), 'h1F);
    out_if.out_ready = 1'b1;
    step();
    out_if.out_ready = 1'b0;
    check("single_popped", int'(level), 0);

    // Four channels captured on one edge, drained in channel order.
    pulse_reset();
    step();
    in_data = {7'h44, 7'h33, 7'h22, 7'h11};
    cap_en  = 4'hF;
    step();
    cap_en = '0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("four_level", int'(level), i);
    end
    for (int i = 0; i < 4; i++) begin
      check("four_ch", int'(out_if.out_ch), i);
      check("four_data", int'(out_if.out_data), (i + 1) * 'h11);
      out_if.out_ready = 1'b1;
      step();
    end
    out_if.out_ready = 1'b0;
    check("four_empty", int'(level), 0);

    // Overrun on ch2 while the FIFO is full.
    cap_en = 4'hF;
    step();
    cap_en = '0;
    for (int i = 0; i < 4; i++) step();
    check("ovr_full", int'(level), 4);
    in_data[14 +: 7] = 7'h05;
    cap_en = 4'b0100;
    step();
    in_data[14 +: 7] = 7'h06;
    step();
    cap_en = '0;
    check("ovr_drop", int'(drop), 4'b0100);
    check("ovr_level", int'(level), 4);
    out_if.out_ready = 1'b1;
    step();
    out_if.out_ready = 1'b0;
    check("ovr_no_push_on_full_pop", int'(level), 3);
    step();
    check("ovr_refill", int'(level), 4);
    for (int i = 0; i < 4; i++) begin
      heads_ch[i]  = int'(out_if.out_ch);
      heads_dat[i] = int'(out_if.out_data);
      out_if.out_ready = 1'b1;
      step();
    end
    out_if.out_ready = 1'b0;
    check("ovr_h0_ch", heads_ch[0], 1);
    check("ovr_h0_data", heads_dat[0], 'h22);
    check("ovr_h2_ch", heads_ch[2], 3);
    check("ovr_h3_ch", heads_ch[3], 2);
    check("ovr_h3_data", heads_dat[3], 'h06);
    drop_clr = 4'b0100;
    step();
    drop_clr = '0;
    check("ovr_cleared", int'(drop), 0);

    // Async reset mid-operation with three buffered entries and one pending capture.
    cap_en = 4'b0111;
    step();
    cap_en = '0;
    for (int i = 0; i < 3; i++) step();
    check("mid_level3", int'(level), 3);
    cap_en = 4'b1000;
    step();
    cap_en = '0;
    pulse_reset();
    step();
    in_data = 28'h000001F;
    cap_en  = 4'b0001;
    step();
    cap_en = '0;
    step();
    check("post_rst_level", int'(level), 1);
    check("post_rst_ch", int'(out_if.out_ch), 0);
    check("post_rst_data", int'(out_if.out_data), 'h1F);
    out_if.out_ready = 1'b1;
    step();

    // Randomized traffic with varying back-pressure, drop clears and rare resets.
    for (int blk = 0; blk < 8; blk++) begin
      rdy_pct = (blk % 4) * 30 + 5;
      for (int i = 0; i < 200; i++) begin
        step();
        in_data          = 28'($urandom);
        cap_en           = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
        out_if.out_ready = ($urandom_range(0, 99) < rdy_pct);
        drop_clr         = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
        if ($urandom_range(0, 299) == 0) pulse_reset();
      end
    end
    cap_en   = '0;
    drop_clr = '0;
    out_if.out_ready = 1'b1;

    // Posedge instance: ch1 captured only on a posedge, visible after the second posedge.
    step();
    p_in_data = 28'h2A << 7;
    p_cap_en  = 4'b0010;
    @(negedge clk);
    #1;
    check("pos_no_neg_capture", int'(dut_p.pend), 0);
    check("pos_valid_0", int'(p_if.out_valid), 0);
    @(posedge clk);
    #1;
    p_cap_en = '0;
    check("pos_captured", int'(dut_p.pend), 4'b0010);
    check("pos_valid_1", int'(p_if.out_valid), 0);
    @(posedge clk);
    #1;
    check("pos_valid_2", int'(p_if.out_valid), 1);
    check("pos_ch", int'(p_if.out_ch), 1);
    check("pos_data", int'(p_if.out_data), 'h2A);
    check("pos_level", int'(p_level), 1);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
